dly_ld_sequencer: RTL and testbench

Sequences delay programming for one byte lane of DDR3 PHY single-bit DQ/DM I/O cells. Each cell has a shared 8-bit delay bus, per-cell set strobes (load a staged value) and ld strobes (apply the staged value). Software-side requests arrive over a valid/ready command port; the block drives the shared `dly_data` bus and one-hot set strobes, tracks which cells hold staged values, and issues a single simultaneous ld on commit followed by a settle interval. Runs in the clk_div domain of the I/O cells it controls.

---
 rtl/dly_ld_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_dly_ld_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dly_ld_sequencer.sv
// dly_ld_sequencer
//   Sequences delay programming for one byte lane of DDR3 PHY DQ/DM I/O cells.
//   Commands arrive on a valid/ready port. The block drives the shared delay bus
//   and one-hot set strobes, and tracks which cells hold staged values. On commit
//   it applies every staged value with one simultaneous ld pulse, then holds off
//   new commands for a settle interval. Runs in the clk_div domain of the cells.
//
// Ports
//   clk         clk_div-domain clock
//   rst_n       synchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   command accepted on this edge if cmd_valid (high only in IDLE)
//   cmd_op      00 SET_ONE, 01 SET_ALL, 10 COMMIT, 11 CLEAR
//   cmd_lane    target cell for SET_ONE
//   cmd_dir     0 = output delay, 1 = input delay
//   cmd_delay   delay value (3 LSBs are the fine delay)
//   dly_data    shared delay bus; holds its last value outside SET
//   set_odelay  per-cell output-delay load strobe
//   set_idelay  per-cell input-delay load strobe
//   ld_odelay   per-cell output-delay apply strobe
//   ld_idelay   per-cell input-delay apply strobe
//   pend_out    cells with a staged, uncommitted output delay
//   pend_in     cells with a staged, uncommitted input delay
//   busy        high whenever the sequencer is not IDLE
//   err         one-cycle pulse when SET_ONE targets a non-existent cell
module dly_ld_sequencer #(
  parameter int NUM_LANES     = 10,
  parameter int LANE_W        = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [LANE_W-1:0]    cmd_lane,
  input  logic                 cmd_dir,
  input  logic [7:0]           cmd_delay,
  output logic [7:0]           dly_data,
  output logic [NUM_LANES-1:0] set_odelay,
  output logic [NUM_LANES-1:0] set_idelay,
  output logic [NUM_LANES-1:0] ld_odelay,
  output logic [NUM_LANES-1:0] ld_idelay,
  output logic [NUM_LANES-1:0] pend_out,
  output logic [NUM_LANES-1:0] pend_in,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, SET, LD, SETTLE} state_t;

  localparam logic [1:0] OP_SET_ONE = 2'b00;
  localparam logic [1:0] OP_SET_ALL = 2'b01;
  localparam logic [1:0] OP_COMMIT  = 2'b10;
  localparam logic [1:0] OP_CLEAR   = 2'b11;
  localparam logic [3:0] SETTLE_N   = 4'(SETTLE_CYCLES);

  state_t               state_q, state_d;
  logic [7:0]           dly_data_q, dly_data_d;
  logic [NUM_LANES-1:0] set_o_q, set_o_d;
  logic [NUM_LANES-1:0] set_i_q, set_i_d;
  logic [NUM_LANES-1:0] ld_o_q, ld_o_d;
  logic [NUM_LANES-1:0] ld_i_q, ld_i_d;
  logic [NUM_LANES-1:0] pend_out_q, pend_out_d;
  logic [NUM_LANES-1:0] pend_in_q, pend_in_d;
  logic                 err_q, err_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q;
  logic [NUM_LANES-1:0] lane_hot;
  logic [NUM_LANES-1:0] set_mask;
  logic                 lane_ok;

  always_comb begin
    state_d    = state_q;
    dly_data_d = dly_data_q;
    set_o_d    = '0;
    set_i_d    = '0;
    ld_o_d     = '0;
    ld_i_d     = '0;
    pend_out_d = pend_out_q;
    pend_in_d  = pend_in_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    set_mask   = '0;

    for (int i = 0; i < NUM_LANES; i++) begin
      lane_hot[i] = (int'(cmd_lane) == i);
    end
    lane_ok = (int'(cmd_lane) < NUM_LANES);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_SET_ONE, OP_SET_ALL: begin
              set_mask = (cmd_op == OP_SET_ALL) ? '1 : lane_hot;
              if (cmd_op == OP_SET_ONE && !lane_ok) begin
                // Out-of-range lane: flag it and stay ready, nothing staged.
                err_d = 1'b1;
              end else begin
                state_d    = SET;
                dly_data_d = cmd_delay;
                if (cmd_dir) begin
                  set_i_d   = set_mask;
                  pend_in_d = pend_in_q | set_mask;
                end else begin
                  set_o_d    = set_mask;
                  pend_out_d = pend_out_q | set_mask;
                end
              end
            end
            OP_COMMIT: begin
              // Apply everything staged so far in one simultaneous ld pulse.
              state_d    = LD;
              ld_o_d     = pend_out_q;
              ld_i_d     = pend_in_q;
              pend_out_d = '0;
              pend_in_d  = '0;
            end
            OP_CLEAR: begin
              pend_out_d = '0;
              pend_in_d  = '0;
            end
            default: ;
          endcase
        end
      end
      SET: state_d = IDLE;
      LD: begin
        if (SETTLE_N == 4'd0) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
          cnt_d   = SETTLE_N;
        end
      end
      SETTLE: begin
        // cnt_q counts the remaining settle cycles including this one.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dly_data_q  <= '0;
      set_o_q     <= '0;
      set_i_q     <= '0;
      ld_o_q      <= '0;
      ld_i_q      <= '0;
      pend_out_q  <= '0;
      pend_in_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_data_q  <= dly_data_d;
      set_o_q     <= set_o_d;
      set_i_q     <= set_i_d;
      ld_o_q      <= ld_o_d;
      ld_i_q      <= ld_i_d;
      pend_out_q  <= pend_out_d;
      pend_in_q   <= pend_in_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= !cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign dly_data   = dly_data_q;
  assign set_odelay = set_o_q;
  assign set_idelay = set_i_q;
  assign ld_odelay  = ld_o_q;
  assign ld_idelay  = ld_i_q;
  assign pend_out   = pend_out_q;
  assign pend_in    = pend_in_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dly_ld_sequencer.sv
// Testbench for dly_ld_sequencer: table of per-cycle vectors (inputs applied
// before an edge, expected outputs after it), plus hand-written reset sequences.
module tb_dly_ld_sequencer;

  localparam int NL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_lane;
  logic          cmd_dir;
  logic [7:0]    cmd_delay;
  logic [7:0]    dly_data;
  logic [NL-1:0] set_odelay, set_idelay, ld_odelay, ld_idelay, pend_out, pend_in;
  logic          busy, err;

  int checks = 0;
  int errors = 0;

  dly_ld_sequencer #(.NUM_LANES(NL), .LANE_W(4), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_lane(cmd_lane), .cmd_dir(cmd_dir), .cmd_delay(cmd_delay),
    .dly_data(dly_data), .set_odelay(set_odelay), .set_idelay(set_idelay),
    .ld_odelay(ld_odelay), .ld_idelay(ld_idelay), .pend_out(pend_out),
    .pend_in(pend_in), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic        vld;
    logic [1:0]  op;
    logic [3:0]  lane;
    logic        dir;
    logic [7:0]  dl;
    logic [7:0]  e_dly;
    logic [9:0]  e_so, e_si, e_lo, e_li, e_po, e_pi;
    logic        e_rdy, e_busy, e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r, input logic vld,
                     input logic [1:0] op, input logic [3:0] ln, input logic d,
                     input logic [7:0] dl, input logic [7:0] edl,
                     input logic [9:0] eso, input logic [9:0] esi,
                     input logic [9:0] elo, input logic [9:0] eli,
                     input logic [9:0] epo, input logic [9:0] epi,
                     input logic erdy, input logic ebusy, input logic eerr);
    vec_t v;
    v.nm = nm; v.rst = r; v.vld = vld; v.op = op; v.lane = ln; v.dir = d; v.dl = dl;
    v.e_dly = edl; v.e_so = eso; v.e_si = esi; v.e_lo = elo; v.e_li = eli;
    v.e_po = epo; v.e_pi = epi; v.e_rdy = erdy; v.e_busy = ebusy; v.e_err = eerr;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [7:0] edl,
                           input logic [9:0] eso, input logic [9:0] esi,
                           input logic [9:0] elo, input logic [9:0] eli,
                           input logic [9:0] epo, input logic [9:0] epi,
                           input logic erdy, input logic ebusy, input logic eerr);
    chk({nm, ".dly_data"},   32'(dly_data),   32'(edl));
    chk({nm, ".set_odelay"}, 32'(set_odelay), 32'(eso));
    chk({nm, ".set_idelay"}, 32'(set_idelay), 32'(esi));
    chk({nm, ".ld_odelay"},  32'(ld_odelay),  32'(elo));
    chk({nm, ".ld_idelay"},  32'(ld_idelay),  32'(eli));
    chk({nm, ".pend_out"},   32'(pend_out),   32'(epo));
    chk({nm, ".pend_in"},    32'(pend_in),    32'(epi));
    chk({nm, ".cmd_ready"},  32'(cmd_ready),  32'(erdy));
    chk({nm, ".busy"},       32'(busy),       32'(ebusy));
    chk({nm, ".err"},        32'(err),        32'(eerr));
  endtask

  task automatic drive(input logic r, input logic vld, input logic [1:0] op,
                       input logic [3:0] ln, input logic d, input logic [7:0] dl);
    rst_n = r; cmd_valid = vld; cmd_op = op; cmd_lane = ln; cmd_dir = d; cmd_delay = dl;
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 8'h00);

    //   name        rst vld op    lane dir dly    e_dly  so      si      lo      li      po      pi      rdy busy err
    add("reset",     0, 0, 2'd0, 4'd0, 0, 8'h00, 8'h00, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 0);
    add("idle0",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h00, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 0);
    add("set3_o",    1, 1, 2'd0, 4'd3, 0, 8'h5A, 8'h5A, 10'h008,10'h000,10'h000,10'h000,10'h008,10'h000, 0, 1, 0);
    add("after_set", 1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h5A, 10'h000,10'h000,10'h000,10'h000,10'h008,10'h000, 1, 0, 0);
    add("lane12_err",1, 1, 2'd0, 4'd12,0, 8'h77, 8'h5A, 10'h000,10'h000,10'h000,10'h000,10'h008,10'h000, 1, 0, 1);
    add("err_drop",  1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h5A, 10'h000,10'h000,10'h000,10'h000,10'h008,10'h000, 1, 0, 0);
    add("set0_i",    1, 1, 2'd0, 4'd0, 1, 8'h10, 8'h10, 10'h000,10'h001,10'h000,10'h000,10'h008,10'h001, 0, 1, 0);
    add("idle1",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h10, 10'h000,10'h000,10'h000,10'h000,10'h008,10'h001, 1, 0, 0);
    add("setall_o",  1, 1, 2'd1, 4'd7, 0, 8'h22, 8'h22, 10'h3FF,10'h000,10'h000,10'h000,10'h3FF,10'h001, 0, 1, 0);
    add("idle2",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h22, 10'h000,10'h000,10'h000,10'h000,10'h3FF,10'h001, 1, 0, 0);
    add("commit1_ld",1, 1, 2'd2, 4'd0, 0, 8'h00, 8'h22, 10'h000,10'h000,10'h3FF,10'h001,10'h000,10'h000, 0, 1, 0);
    add("c1_st3_ign",1, 1, 2'd0, 4'd1, 0, 8'hEE, 8'h22, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c1_st2",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h22, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c1_st1",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h22, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c1_idle",   1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h22, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 0);
    add("set5_a",    1, 1, 2'd0, 4'd5, 0, 8'h11, 8'h11, 10'h020,10'h000,10'h000,10'h000,10'h020,10'h000, 0, 1, 0);
    add("idle3",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h11, 10'h000,10'h000,10'h000,10'h000,10'h020,10'h000, 1, 0, 0);
    add("set5_b",    1, 1, 2'd0, 4'd5, 0, 8'h33, 8'h33, 10'h020,10'h000,10'h000,10'h000,10'h020,10'h000, 0, 1, 0);
    add("idle4",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h33, 10'h000,10'h000,10'h000,10'h000,10'h020,10'h000, 1, 0, 0);
    add("commit2_ld",1, 1, 2'd2, 4'd0, 0, 8'h00, 8'h33, 10'h000,10'h000,10'h020,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c2_st3",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h33, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c2_st2",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h33, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c2_st1",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h33, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c2_idle",   1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h33, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 0);
    add("set2_o",    1, 1, 2'd0, 4'd2, 0, 8'h44, 8'h44, 10'h004,10'h000,10'h000,10'h000,10'h004,10'h000, 0, 1, 0);
    add("idle5",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h004,10'h000, 1, 0, 0);
    add("clear",     1, 1, 2'd3, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 0);
    add("commit3_ld",1, 1, 2'd2, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c3_st3",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c3_st2",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c3_st1",    1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 0, 1, 0);
    add("c3_idle",   1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 0);
    add("lane10_err",1, 1, 2'd0, 4'd10,1, 8'h55, 8'h44, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h000, 1, 0, 1);
    add("set9_i",    1, 1, 2'd0, 4'd9, 1, 8'h66, 8'h66, 10'h000,10'h200,10'h000,10'h000,10'h000,10'h200, 0, 1, 0);
    add("idle6",     1, 0, 2'd0, 4'd0, 0, 8'h00, 8'h66, 10'h000,10'h000,10'h000,10'h000,10'h000,10'h200, 1, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].vld, tbl[k].op, tbl[k].lane, tbl[k].dir, tbl[k].dl);
      tick();
      check_all($sformatf("v%0d_%s", k, tbl[k].nm), tbl[k].e_dly, tbl[k].e_so, tbl[k].e_si,
                tbl[k].e_lo, tbl[k].e_li, tbl[k].e_po, tbl[k].e_pi,
                tbl[k].e_rdy, tbl[k].e_busy, tbl[k].e_err);
    end

    // Reset asserted while in SET.
    drive(1'b1, 1'b1, 2'd0, 4'd4, 1'b0, 8'h99);
    tick();
    check_all("rs_set", 8'h99, 10'h010, 10'h000, 10'h000, 10'h000, 10'h010, 10'h200, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs_set_rst", 8'h00, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs_set_rel", 8'h00, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0);

    // Reset asserted while in SETTLE.
    drive(1'b1, 1'b1, 2'd1, 4'd0, 1'b1, 8'hAB);
    tick();
    check_all("rs2_setall", 8'hAB, 10'h000, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h3FF, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs2_idle", 8'hAB, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h3FF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs2_ld", 8'hAB, 10'h000, 10'h000, 10'h000, 10'h3FF, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs2_settle", 8'hAB, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs2_rst", 8'h00, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();
    check_all("rs2_rel", 8'h00, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0);
    // A command right after release is accepted immediately.
    drive(1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 8'h01);
    tick();
    check_all("rs2_newcmd", 8'h01, 10'h002, 10'h000, 10'h000, 10'h000, 10'h002, 10'h000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
